// File: rtl/memory_access_pkg.sv
// Shared types for the RV64 memory stage: execute/memory bundles, data-bus
// request/response, access-size encoding and the stage FSM states.
package memory_access_pkg;

   localparam int DBUS_W = 64;

   typedef enum logic [2:0] {
      MSIZE1 = 3'd0,
      MSIZE2 = 3'd1,
      MSIZE4 = 3'd2,
      MSIZE8 = 3'd3
   } msize_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DONE
   } ms_state_t;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic              mem_to_reg;
      logic              mem_write;
      logic [DBUS_W-1:0] aluout;
      logic [DBUS_W-1:0] write_data;
      logic [4:0]        write_reg;
      logic [63:0]       pc_now;
      logic [31:0]       raw_instr;
   } data_execute_t;

   typedef struct packed {
      logic              valid;
      logic              reg_write;
      logic [4:0]        write_reg;
      logic [DBUS_W-1:0] result;
      logic              misaligned;
      logic [63:0]       pc_now;
      logic [31:0]       raw_instr;
   } data_memory_t;

   typedef struct packed {
      logic              valid;
      logic [63:0]       addr;
      msize_t            size;
      logic [7:0]        strobe;
      logic [DBUS_W-1:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic              addr_ok;
      logic              data_ok;
      logic [DBUS_W-1:0] data;
   } dbus_resp_t;

   // Number of bytes touched for funct3[1:0] = 0/1/2/3.
   function automatic logic [3:0] size_bytes(input logic [1:0] f);
      size_bytes = 4'd1 << f;
   endfunction

   // Low-address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] size_mask(input logic [1:0] f);
      logic [3:0] nb;
      nb = size_bytes(f) - 4'd1;
      size_mask = nb[2:0];
   endfunction

endpackage

// File: rtl/memory_access_align.sv
// Combinational lane logic: store strobe/data placement, load shift and
// sign/zero extension, and natural-alignment check.
module mem_align
   import memory_access_pkg::*;
(
   input  logic [2:0]        funct3,
   input  logic [2:0]        addr_lo,
   input  logic [DBUS_W-1:0] write_data,
   input  logic [DBUS_W-1:0] read_data,
   output logic [7:0]        strobe,
   output logic [DBUS_W-1:0] store_data,
   output logic [DBUS_W-1:0] load_data,
   output logic              misaligned
);

   logic [3:0]        nbytes;
   logic [5:0]        sh;
   logic [DBUS_W-1:0] raw;
   logic              sext;

   assign nbytes     = size_bytes(funct3[1:0]);
   assign sh         = {addr_lo, 3'b000};
   assign misaligned = (addr_lo & size_mask(funct3[1:0])) != 3'd0;
   assign store_data = write_data << sh;
   assign raw        = read_data >> sh;
   assign sext       = ~funct3[2];

   // Byte lane gi is enabled when it lies inside [addr_lo, addr_lo+nbytes).
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_lane
         assign strobe[gi] = (4'(gi) >= {1'b0, addr_lo}) &&
                             (4'(gi) <  ({1'b0, addr_lo} + nbytes));
      end
   endgenerate

   always_comb begin
      load_data = raw;
      case (funct3[1:0])
         2'd0:    load_data = {{56{raw[7]  & sext}}, raw[7:0]};
         2'd1:    load_data = {{48{raw[15] & sext}}, raw[15:0]};
         2'd2:    load_data = {{32{raw[31] & sext}}, raw[31:0]};
         default: load_data = raw;
      endcase
   end

endmodule

// File: rtl/memory_access.sv
// Memory stage: issues data-bus requests for aligned loads/stores, stalls
// upstream while the access is outstanding, and forwards everything else.
module memory_access
   import memory_access_pkg::*;
#(
   parameter int DATA_W = 64
)
(
   input  logic          clk,
   input  logic          reset,
   input  data_execute_t data_e,
   input  logic          stall_in,
   output dbus_req_t     dreq,
   input  dbus_resp_t    dresp,
   output data_memory_t  data_m,
   output logic          stall_m
);

   ms_state_t         state_reg;
   logic [DATA_W-1:0] buffer_reg;

   logic [2:0]        funct3;
   logic              is_mem;
   logic              is_load;
   logic              misaligned;
   logic              issue_cond;
   logic              issue;
   logic [7:0]        strobe;
   logic [DBUS_W-1:0] store_data;
   logic [DBUS_W-1:0] load_data;

   assign funct3  = data_e.raw_instr[14:12];
   assign is_mem  = data_e.valid & (data_e.mem_to_reg | data_e.mem_write);
   assign is_load = data_e.mem_to_reg;

   mem_align u_align (
      .funct3     (funct3),
      .addr_lo    (data_e.aluout[2:0]),
      .write_data (data_e.write_data),
      .read_data  (buffer_reg),
      .strobe     (strobe),
      .store_data (store_data),
      .load_data  (load_data),
      .misaligned (misaligned)
   );

   // The issue-cycle request is combinational, so it is also masked by reset.
   assign issue_cond = (state_reg == IDLE) & is_mem & ~misaligned;
   assign issue      = issue_cond & ~reset;
   assign stall_m    = issue | (state_reg == REQ) | (state_reg == WAIT);

   always_comb begin
      dreq       = '0;
      dreq.valid = issue | (state_reg == REQ);
      dreq.addr  = data_e.aluout;
      dreq.size  = msize_t'({1'b0, funct3[1:0]});
      if (!is_load) begin
         dreq.strobe = strobe;
         dreq.data   = store_data;
      end
   end

   always_comb begin
      data_m           = '0;
      data_m.write_reg = data_e.write_reg;
      data_m.pc_now    = data_e.pc_now;
      data_m.raw_instr = data_e.raw_instr;
      if (state_reg == DONE) begin
         data_m.valid     = 1'b1;
         data_m.reg_write = data_e.reg_write & data_e.mem_to_reg;
         data_m.result    = is_load ? load_data : '0;
      end else if ((state_reg == IDLE) && !stall_m && !reset) begin
         data_m.valid = data_e.valid;
         if (is_mem) begin
            // Only a misaligned access reaches here: dropped without a bus cycle.
            data_m.misaligned = 1'b1;
         end else begin
            data_m.reg_write = data_e.reg_write;
            data_m.result    = data_e.aluout;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         buffer_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (issue_cond) begin
                  if (dresp.addr_ok && dresp.data_ok) begin
                     state_reg  <= DONE;
                     buffer_reg <= dresp.data;
                  end else if (dresp.addr_ok) begin
                     state_reg <= WAIT;
                  end else begin
                     state_reg <= REQ;
                  end
               end
            end
            REQ: begin
               // A data_ok without addr_ok here is spurious and ignored.
               if (dresp.addr_ok && dresp.data_ok) begin
                  state_reg  <= DONE;
                  buffer_reg <= dresp.data;
               end else if (dresp.addr_ok) begin
                  state_reg <= WAIT;
               end
            end
            WAIT: begin
               if (dresp.data_ok) begin
                  state_reg  <= DONE;
                  buffer_reg <= dresp.data;
               end
            end
            DONE: begin
               if (!stall_in) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: bus handshake timing, lane/strobe
// generation, load extension, misalignment, reset abort and output hold.
module tb_memory_access;
   import memory_access_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   data_execute_t data_e;
   logic          stall_in;
   dbus_req_t     dreq;
   dbus_resp_t    dresp;
   data_memory_t  data_m;
   logic          stall_m;

   memory_access #(.DATA_W(64)) dut (
      .clk      (clk),
      .reset    (reset),
      .data_e   (data_e),
      .stall_in (stall_in),
      .dreq     (dreq),
      .dresp    (dresp),
      .data_m   (data_m),
      .stall_m  (stall_m)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] result;
      logic        reg_write;
      logic        misaligned;
   } exp_t;

   exp_t sb_q[$];
   exp_t cur;
   int   n_assert = 0;
   int   n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic data_execute_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                        input logic [63:0] addr, input logic [63:0] wd,
                                        input logic rw);
      data_execute_t d;
      d            = '0;
      d.valid      = 1'b1;
      d.reg_write  = rw;
      d.mem_to_reg = ld;
      d.mem_write  = st;
      d.aluout     = addr;
      d.write_data = wd;
      d.write_reg  = 5'd7;
      d.pc_now     = 64'h0000_0000_8000_0100;
      d.raw_instr  = {17'd0, f3, 5'd7, 7'h03};
      return d;
   endfunction

   function automatic exp_t mkexp(input logic [63:0] r, input logic rw, input logic mis);
      exp_t e;
      e.result     = r;
      e.reg_write  = rw;
      e.misaligned = mis;
      return e;
   endfunction

   task automatic pop_compare(input string tag);
      n_assert++;
      assert (sb_q.size() > 0) else begin
         n_fail++;
         $error("FAIL %s_sb_empty observed=0 expected=1", tag);
      end
      if (sb_q.size() > 0) begin
         cur = sb_q.pop_front();
         chk({tag, "_result"},  data_m.result, cur.result);
         chk({tag, "_regwr"},   64'(data_m.reg_write), 64'(cur.reg_write));
         chk({tag, "_misalgn"}, 64'(data_m.misaligned), 64'(cur.misaligned));
      end
   endtask

   // Drives one bus access: addr_ok at cycle ac, data_ok at dc, optional
   // spurious data_ok at spur, then optionally holds DONE with stall_in.
   task automatic run_mem(input string tag, input data_execute_t ins, input int ac, input int dc,
                          input int spur, input logic [63:0] rdata, input exp_t e,
                          input logic [7:0] e_strobe, input logic [63:0] e_wdata,
                          input logic [2:0] e_size, input int hold);
      bit done;
      done   = 1'b0;
      data_e = ins;
      sb_q.push_back(e);
      for (int c = 0; c < 20 && !done; c++) begin
         dresp.addr_ok = (c == ac);
         dresp.data_ok = (c == dc) || (c == spur);
         dresp.data    = (c == spur) ? 64'hDEAD_BEEF_DEAD_BEEF : rdata;
         #1;
         if (c == 0) begin
            chk({tag, "_addr"},   dreq.addr, ins.aluout);
            chk({tag, "_size"},   64'(dreq.size), 64'(e_size));
            chk({tag, "_strobe"}, 64'(dreq.strobe), 64'(e_strobe));
            chk({tag, "_wdata"},  dreq.data, e_wdata);
         end
         chk({tag, "_stall"},  64'(stall_m), 64'(c <= dc));
         chk({tag, "_dvalid"}, 64'(dreq.valid), 64'(c <= ac));
         chk({tag, "_mvalid"}, 64'(data_m.valid), 64'(c > dc));
         if (c > dc) begin
            done = 1'b1;
            pop_compare(tag);
         end else begin
            tick();
         end
      end
      dresp    = '0;
      stall_in = 1'b1;
      for (int h = 0; h < hold; h++) begin
         tick();
         chk({tag, "_hold_mvalid"}, 64'(data_m.valid), 64'd1);
         chk({tag, "_hold_result"}, data_m.result, cur.result);
         chk({tag, "_hold_stall"},  64'(stall_m), 64'd0);
      end
      stall_in = 1'b0;
      data_e   = '0;
      tick();
   endtask

   task automatic run_comb(input string tag, input data_execute_t ins, input exp_t e);
      data_e = ins;
      sb_q.push_back(e);
      #1;
      chk({tag, "_dvalid"}, 64'(dreq.valid), 64'd0);
      chk({tag, "_stall"},  64'(stall_m), 64'd0);
      chk({tag, "_mvalid"}, 64'(data_m.valid), 64'd1);
      pop_compare(tag);
      data_e = '0;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b1;
      data_e   = '0;
      dresp    = '0;
      stall_in = 1'b0;
      #1;
      chk("rst_dvalid", 64'(dreq.valid), 64'd0);
      chk("rst_stall",  64'(stall_m), 64'd0);
      chk("rst_mvalid", 64'(data_m.valid), 64'd0);
      data_e = mk(1'b1, 1'b0, 3'd3, 64'h8000_1000, 64'd0, 1'b1);
      #1;
      chk("rst_ld_dvalid", 64'(dreq.valid), 64'd0);
      data_e = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      run_mem("ld", mk(1'b1, 1'b0, 3'd3, 64'h8000_1000, 64'd0, 1'b1), 1, 3, -1,
              64'h1122_3344_5566_7788, mkexp(64'h1122_3344_5566_7788, 1'b1, 1'b0),
              8'h00, 64'd0, 3'd0 + 3'd3, 0);
      run_mem("sb", mk(1'b0, 1'b1, 3'd0, 64'h8000_0005, 64'hAB, 1'b0), 1, 2, -1,
              64'd0, mkexp(64'd0, 1'b0, 1'b0), 8'h20, 64'h0000_AB00_0000_0000, 3'd0, 0);
      run_mem("lb", mk(1'b1, 1'b0, 3'd0, 64'h8000_0003, 64'd0, 1'b1), 1, 2, -1,
              64'h0000_0000_8000_0000, mkexp(64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0),
              8'h00, 64'd0, 3'd0, 0);
      run_mem("lbu", mk(1'b1, 1'b0, 3'd4, 64'h8000_0003, 64'd0, 1'b1), 1, 2, -1,
              64'h0000_0000_8000_0000, mkexp(64'h80, 1'b1, 1'b0), 8'h00, 64'd0, 3'd0, 0);
      run_mem("lw", mk(1'b1, 1'b0, 3'd2, 64'h8000_0004, 64'd0, 1'b1), 0, 0, -1,
              64'h89AB_CDEF_0000_0000, mkexp(64'hFFFF_FFFF_89AB_CDEF, 1'b1, 1'b0),
              8'h00, 64'd0, 3'd2, 0);
      run_mem("sw", mk(1'b0, 1'b1, 3'd2, 64'h8000_0004, 64'h1234_5678_CAFE_BABE, 1'b0), 0, 1, -1,
              64'd0, mkexp(64'd0, 1'b0, 1'b0), 8'hF0, 64'hCAFE_BABE_0000_0000, 3'd2, 0);
      run_mem("lhu", mk(1'b1, 1'b0, 3'd5, 64'h8000_0006, 64'd0, 1'b1), 2, 4, 1,
              64'hBEEF_0000_0000_0000, mkexp(64'hBEEF, 1'b1, 1'b0), 8'h00, 64'd0, 3'd1, 0);

      run_comb("mis_lw", mk(1'b1, 1'b0, 3'd2, 64'h1002, 64'd0, 1'b1), mkexp(64'd0, 1'b0, 1'b1));
      run_comb("alu", mk(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 1'b1), mkexp(64'h1234, 1'b1, 1'b0));

      // Abandon an access in WAIT with reset, then reissue it.
      data_e        = mk(1'b1, 1'b0, 3'd3, 64'h8000_2000, 64'd0, 1'b1);
      dresp.addr_ok = 1'b1;
      #1;
      chk("abort_issue_dvalid", 64'(dreq.valid), 64'd1);
      tick();
      dresp = '0;
      #1;
      chk("abort_wait_dvalid", 64'(dreq.valid), 64'd0);
      chk("abort_wait_stall",  64'(stall_m), 64'd1);
      reset = 1'b1;
      #1;
      chk("abort_rst_dvalid", 64'(dreq.valid), 64'd0);
      chk("abort_rst_stall",  64'(stall_m), 64'd0);
      tick();
      reset = 1'b0;
      run_mem("reissue", mk(1'b1, 1'b0, 3'd3, 64'h8000_2000, 64'd0, 1'b1), 1, 2, -1,
              64'h0F0E_0D0C_0B0A_0908, mkexp(64'h0F0E_0D0C_0B0A_0908, 1'b1, 1'b0),
              8'h00, 64'd0, 3'd3, 0);

      run_mem("lh_hold", mk(1'b1, 1'b0, 3'd1, 64'h8000_0002, 64'd0, 1'b1), 1, 2, -1,
              64'h0000_0000_8001_0000, mkexp(64'hFFFF_FFFF_FFFF_8001, 1'b1, 1'b0),
              8'h00, 64'd0, 3'd1, 3);
      run_comb("after_hold", mk(1'b0, 1'b0, 3'd0, 64'h55AA, 64'd0, 1'b0), mkexp(64'h55AA, 1'b0, 1'b0));

      chk("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the 5-stage RV64 pipeline. It consumes the execute-stage bundle and, for loads and stores, drives the data-bus request/response handshake.
- Loads are aligned and extended. Stores get strobe and data lanes generated. Non-memory instructions pass through with zero added latency.
- While a bus access is outstanding the block raises a stall that freezes all earlier stages.

Parameters:
- DATA_W, 64, data bus and register width. Only 64 is supported.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- data_e  in  data_execute_t  execute bundle (valid, reg_write, mem_to_reg, mem_write, aluout as address, write_data, write_reg, pc_now, raw_instr); held stable while stall_m=1
- stall_in  in  1  later stage cannot accept; hold the current result
- dreq  out  dbus_req_t  valid, addr[63:0], size[2:0], strobe[7:0], data[63:0]
- dresp  in  dbus_resp_t  addr_ok, data_ok, data[63:0]
- data_m  out  data_memory_t  valid, reg_write, write_reg, result[63:0], misaligned, pc_now, raw_instr
- stall_m  out  1  freeze upstream stages

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high: state goes to IDLE, the capture buffer clears to 0, and dreq.valid=0.
- Instruction classes:
  - mem = data_e.valid & (mem_to_reg | mem_write).
  - funct3 = raw_instr[14:12]; size = 1/2/4/8 bytes for funct3[1:0] = 0/1/2/3.
- Misaligned access: addr[2:0] not a multiple of size. No bus request is issued. data_m passes through at once with misaligned=1, reg_write=0, result=0.
- State IDLE:
  - Non-mem or misaligned: data_m is combinational from data_e; result = aluout for non-mem; stall_m=0.
  - Aligned mem: dreq.valid=1 combinationally; stall_m=1; go to REQ.
  - If addr_ok arrives in that same cycle, go to WAIT; if data_ok also arrives, go to DONE.
- State REQ:
  - Hold dreq.valid=1 and all dreq fields constant until addr_ok.
  - addr_ok & data_ok in the same cycle: go to DONE.
  - addr_ok only: go to WAIT.
- State WAIT:
  - dreq.valid=0; wait for data_ok.
  - On data_ok, capture dresp.data into the buffer and go to DONE.
  - data_ok is never expected before addr_ok; if it arrives in REQ without addr_ok, ignore it.
- State DONE:
  - stall_m=0; data_m.valid=1; result comes from the buffer (loads) or is 0 (stores).
  - reg_write = data_e.reg_write & mem_to_reg.
  - If stall_in=1, stay in DONE and keep stall_m=0 (the outer hazard unit combines the stalls). Otherwise go to IDLE.
- stall_m = 1 in REQ and WAIT, and in IDLE when an aligned mem instruction is issuing; otherwise 0.
- data_m.valid = 0 whenever stall_m=1.
- Store lanes:
  - sh = addr[2:0]*8.
  - dreq.data = write_data << sh.
  - strobe = ({1,3,15,255}[size] << addr[2:0]) & 8'hFF.
- Loads: strobe=0; dreq.data=0.
- Load extraction:
  - raw = buffer >> (addr[2:0]*8); take the low size bytes.
  - funct3[2]=0 sign-extends (lb/lh/lw/ld); funct3[2]=1 zero-extends (lbu/lhu/lwu).
- dreq.addr is the full aluout; the memory ignores the low bits and uses the strobe instead.
- Reset during REQ or WAIT abandons the access. The bus side tolerates a dropped request.
- dreq.valid never deasserts before addr_ok.

Decomposition:
- Package pipes: data_memory_t.
- Package common: dbus_req_t, dbus_resp_t, msize_t encodings MSIZE1/2/4/8, state enum ms_state_t {IDLE, REQ, WAIT, DONE}.
- One combinational sub-module mem_align holds lane and strobe generation plus load shift and extend. Its inputs are funct3, addr[2:0], write_data and the raw read data.

Test Plan:
- ld at 0x80001000: addr_ok in cycle 1, data_ok with data=0x1122334455667788 in cycle 3 -> stall_m=1 in cycles 0-3; DONE in cycle 4 with result=0x1122334455667788.
- sb write_data=0xAB at 0x80000005 -> dreq.strobe=0x20, dreq.data=0x0000AB0000000000, size=MSIZE1; data_m.reg_write=0.
- lb at addr ...3, data_ok data=0x0000000080000000 -> result 0xFFFFFFFFFFFFFF80; lbu same input -> 0x80.
- addr_ok and data_ok both in the issue cycle with lw at ...4, data 0x89ABCDEF00000000 -> DONE next cycle, result 0xFFFFFFFF89ABCDEF.
- lw at 0x1002 -> no dreq.valid; same-cycle data_m with misaligned=1, reg_write=0; stall_m=0.
- reset asserted in WAIT -> dreq.valid=0 and state IDLE immediately (async); next instruction issues normally. Separately, stall_in=1 for 3 cycles in DONE -> result held; IDLE afterward.
